// File: rtl/lc3_reg_dump.sv
// lc3_reg_dump: walks the register file display port through R0..R(RLEN-1)
// and streams a framed dump (header, two bytes per register MSB first,
// XOR checksum of the data bytes) to a byte sink.
//
// Byte stream handshake: a byte moves on a rising edge where tx_valid and
// tx_ready are both high. Once tx_valid rises it stays high and tx_data
// stays stable until that transfer happens. tx_ready is don't-care while
// tx_valid is low.
module lc3_reg_dump #(
  parameter int           RLEN     = 8,      // 1..8 (dis_sel bit 3 is always 0)
  parameter logic [7:0]   HDR_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  dis_sel,
  input  logic [15:0] dis_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_SAMPLE  = 3'd2,
    S_SEND_HI = 3'd3,
    S_SEND_LO = 3'd4,
    S_CSUM    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(RLEN - 1);

  state_t      state_q;
  logic [2:0]  idx_q;
  logic [15:0] shadow_q;
  logic [7:0]  csum_q;
  logic [3:0]  dis_sel_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        busy_q;
  logic        done_q;
  logic        fire;

  // A byte is handed over this cycle.
  assign fire = tx_valid_q & tx_ready;

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      shadow_q   <= 16'h0000;
      csum_q     <= 8'h00;
      dis_sel_q  <= 4'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_HDR;
            csum_q     <= 8'h00;
            idx_q      <= 3'd0;
            busy_q     <= 1'b1;
            tx_valid_q <= 1'b1;
            tx_data_q  <= HDR_BYTE;
          end
        end
        S_HDR: begin
          if (fire) begin
            // Select goes out a full cycle ahead of the capture edge.
            state_q    <= S_SAMPLE;
            dis_sel_q  <= {1'b0, idx_q};
            tx_valid_q <= 1'b0;
          end
        end
        S_SAMPLE: begin
          // Capture the register as presented right now; later writes miss this frame.
          shadow_q   <= dis_data;
          tx_data_q  <= dis_data[15:8];
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND_HI;
        end
        S_SEND_HI: begin
          if (fire) begin
            csum_q    <= csum_q ^ shadow_q[15:8];
            tx_data_q <= shadow_q[7:0];
            state_q   <= S_SEND_LO;
          end
        end
        S_SEND_LO: begin
          if (fire) begin
            csum_q <= csum_q ^ shadow_q[7:0];
            if (idx_q != LAST_IDX) begin
              idx_q      <= idx_q + 3'd1;
              dis_sel_q  <= {1'b0, idx_q + 3'd1};
              tx_valid_q <= 1'b0;
              state_q    <= S_SAMPLE;
            end else begin
              // Checksum includes the byte just sent; tx_valid stays high.
              tx_data_q <= csum_q ^ shadow_q[7:0];
              state_q   <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (fire) begin
            tx_valid_q <= 1'b0;
            dis_sel_q  <= 4'd0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          // start is not looked at here, so a request in this cycle is dropped.
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          dis_sel_q  <= 4'd0;
        end
      endcase
    end
  end

  assign dis_sel     = dis_sel_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lc3_reg_dump.sv
// Directed bench for lc3_reg_dump: models the register file display port,
// captures every transferred byte and compares frames against expected queues.
module tb_lc3_reg_dump;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  dis_sel;
  logic [15:0] dis_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  logic [15:0] regs[8];
  logic [15:0] exp_regs[8];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [3:0]  sel_q[$];
  logic [3:0]  last_sel;
  int          cyc;
  int          start_cyc;
  int          done_cyc;
  int          done_cnt;
  int          checks;
  int          failures;

  lc3_reg_dump dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dis_sel     (dis_sel),
    .dis_data    (dis_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // Register file display port: combinational read.
  assign dis_data = regs[dis_sel[2:0]];

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: byte capture, select trace, start/done bookkeeping.
  initial begin
    cyc = 0; start_cyc = 0; done_cyc = 0; done_cnt = 0; last_sel = 4'd0;
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (start && !busy && rst_n) start_cyc <= cyc;
    if (dis_sel != last_sel) sel_q.push_back(dis_sel);
    last_sel <= dis_sel;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic copy_regs();
    for (int i = 0; i < 8; i++) exp_regs[i] = regs[i];
  endtask

  task automatic build_exp();
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(exp_regs[i][15:8]);
      exp_q.push_back(exp_regs[i][7:0]);
      cs = cs ^ exp_regs[i][15:8] ^ exp_regs[i][7:0];
    end
    exp_q.push_back(cs);
  endtask

  task automatic check_frame(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, "_nbytes"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dis_sel", dis_sel, 4'd0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_state", dbg_state, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame: R0=1234, rest zero
    regs[0] = 16'h1234;
    copy_regs(); build_exp();
    got_q.delete(); sel_q.delete();
    d0 = done_cnt;
    pulse_start();
    chk("basic_hdr_valid", tx_valid, 1'b1);
    chk("basic_hdr_data", tx_data, 8'hA5);
    chk("basic_busy", busy, 1'b1);
    chk("basic_sel0", dis_sel, 4'd0);
    wait_done(40);
    chk("basic_done_busy", busy, 1'b1);
    chk("basic_sel_ret", dis_sel, 4'd0);
    @(negedge clk);
    chk("basic_idle_busy", busy, 1'b0);
    chk("basic_idle_done", done, 1'b0);
    chk("basic_len", done_cyc - start_cyc, 27);
    chk("basic_done_cnt", done_cnt - d0, 1);
    if (got_q.size() == 18) chk("basic_csum", got_q[17], 8'h26);
    chk("basic_sel_steps", sel_q.size(), 8);
    for (int i = 0; i < 8 && i < sel_q.size(); i++)
      chk($sformatf("basic_sel%0d", i), sel_q[i], 4'((i + 1) % 8));
    check_frame("basic");

    // Backpressure during SEND_HI of R3
    for (int i = 0; i < 8; i++) regs[i] = 16'(16'h0101 * (i + 1));
    copy_regs(); build_exp();
    pulse_start();
    repeat (11) @(negedge clk);
    chk("bp_pre_data", tx_data, 8'h04);
    chk("bp_pre_state", dbg_state, 3'd3);
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_stall_data", tx_data, 8'h04);
      chk("bp_stall_valid", tx_valid, 1'b1);
    end
    tx_ready = 1'b1;
    wait_done(40);
    @(negedge clk);
    chk("bp_len", done_cyc - start_cyc, 32);
    if (got_q.size() == 18) chk("bp_csum", got_q[17], 8'h00);
    check_frame("bp");

    // Start while busy (cycle 5, and cycles 26..27 of the frame)
    for (int i = 0; i < 8; i++) regs[i] = 16'(16'h1111 * i);
    copy_regs(); build_exp();
    d0 = done_cnt;
    pulse_start();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("swb_done_cnt", done_cnt - d0, 1);
    chk("swb_busy", busy, 1'b0);
    check_frame("swb");

    // Live update landing in R5's SAMPLE cycle: captured
    copy_regs(); exp_regs[5] = 16'hBEEF; build_exp();
    pulse_start();
    repeat (16) @(negedge clk);
    chk("live_pre_sel", dis_sel, 4'd5);
    regs[5] = 16'hBEEF;
    wait_done(40);
    @(negedge clk);
    check_frame("live_pre");

    // Live update after R5's SAMPLE edge: old value kept
    regs[5] = 16'h5555;
    copy_regs(); build_exp();
    pulse_start();
    repeat (17) @(negedge clk);
    regs[5] = 16'hBEEF;
    wait_done(40);
    @(negedge clk);
    check_frame("live_post");
    regs[5] = 16'h5555;

    // Reset during SEND_LO of R2
    pulse_start();
    repeat (9) @(negedge clk);
    chk("rstm_state", dbg_state, 3'd4);
    chk("rstm_sel_pre", dis_sel, 4'd2);
    rst_n = 1'b0;
    #1;
    chk("rstm_tx_valid", tx_valid, 1'b0);
    chk("rstm_busy", busy, 1'b0);
    chk("rstm_done", done, 1'b0);
    chk("rstm_dis_sel", dis_sel, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got_q.delete();
    regs[2] = 16'hC3A7;
    copy_regs(); build_exp();
    pulse_start();
    wait_done(40);
    @(negedge clk);
    chk("rstm_len", done_cyc - start_cyc, 27);
    check_frame("rstm");

    // Back-to-back frames
    for (int i = 0; i < 8; i++) regs[i] = 16'(16'h1357 + 16'(i) * 16'h2468);
    copy_regs(); build_exp(); build_exp();
    pulse_start();
    wait_done(40);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_hdr_valid", tx_valid, 1'b1);
    chk("b2b_hdr_data", tx_data, 8'hA5);
    wait_done(40);
    @(negedge clk);
    chk("b2b_len", done_cyc - start_cyc, 27);
    check_frame("b2b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
